// File: rtl/rr_arb_pkg.sv
// Shared types and index helpers for the round-robin register arbiter.
package rr_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_COOL = 1'b1
    } arb_state_t;

    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Modulo increment that works for non-power-of-two requester counts
    function automatic int wrap_inc(input int v, input int n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module rr_priority_pick
    import rr_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic                       found,
    output logic [$clog2(NUM_REQ)-1:0] win
);

    localparam int ID_W = idx_w(NUM_REQ);
    localparam int W2   = 2 * NUM_REQ;

    logic [W2-1:0] req2;
    logic [W2-1:0] below;
    logic [W2-1:0] masked;

    // Lower copy drops bits below ptr; upper copy supplies the wrapped candidates
    assign req2   = {req, req};
    assign below  = (W2'(1) << ptr) - W2'(1);
    assign masked = req2 & ~below;

    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int j = W2 - 1; j >= 0; j--) begin
            if (masked[j]) begin
                found = 1'b1;
                win   = (j >= NUM_REQ) ? ID_W'(j - NUM_REQ) : ID_W'(j);
            end
        end
    end

endmodule

// File: rtl/rr_reg_arbiter.sv
// Round-robin arbiter sharing one resettable register among NUM_REQ writers,
// with an optional post-write cooldown.
module rr_reg_arbiter
    import rr_arb_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int DATA_W   = 8,
    parameter int COOLDOWN = 0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_i,
    input  logic [NUM_REQ*DATA_W-1:0]   data_i,
    output logic [NUM_REQ-1:0]          ack_o,
    output logic [DATA_W-1:0]           q_o,
    output logic                        q_valid_o,
    output logic [$clog2(NUM_REQ)-1:0]  last_id_o,
    output logic                        busy_o
);

    localparam int ID_W  = idx_w(NUM_REQ);
    localparam int CNT_W = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

    arb_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ID_W-1:0]  ptr_q;
    logic [NUM_REQ-1:0] eff_req;
    logic             found;
    logic [ID_W-1:0]  win_idx;
    logic             load;

    // The just-acknowledged requester is masked so a late req drop is not served twice
    assign eff_req = req_i & ~ack_o;

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req   (eff_req),
        .ptr   (ptr_q),
        .found (found),
        .win   (win_idx)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (found) begin
                    load = 1'b1;
                    if (COOLDOWN > 0) begin
                        state_d = ARB_COOL;
                        cnt_d   = CNT_W'(COOLDOWN);
                    end
                end
            end
            ARB_COOL: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ARB_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ARB_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Registered outputs: everything below changes only on clk or reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ARB_IDLE;
            cnt_q     <= '0;
            ptr_q     <= '0;
            ack_o     <= '0;
            q_o       <= '0;
            q_valid_o <= 1'b0;
            last_id_o <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_o   <= load ? (NUM_REQ'(1) << win_idx) : '0;
            if (load) begin
                q_o       <= data_i[int'(win_idx)*DATA_W +: DATA_W];
                q_valid_o <= 1'b1;
                last_id_o <= win_idx;
                ptr_q     <= ID_W'(wrap_inc(int'(win_idx), NUM_REQ));
            end
        end
    end

    assign busy_o = (state_q == ARB_COOL);

endmodule

// File: tb/tb_rr_reg_arbiter.sv
// Bench for rr_reg_arbiter: a 4-requester no-cooldown instance and a 3-requester
// COOLDOWN=3 instance, each checked every cycle against a behavioural model.
module tb_rr_reg_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b1;

    logic [3:0]  req_a  = '0;
    logic [31:0] data_a = '0;
    logic [3:0]  ack_a;
    logic [7:0]  q_a;
    logic        qv_a;
    logic [1:0]  last_a;
    logic        busy_a;

    logic [2:0]  req_b  = '0;
    logic [23:0] data_b = '0;
    logic [2:0]  ack_b;
    logic [7:0]  q_b;
    logic        qv_b;
    logic [1:0]  last_b;
    logic        busy_b;

    rr_reg_arbiter #(.NUM_REQ(4), .DATA_W(8), .COOLDOWN(0)) dut_a (
        .clk       (clk),
        .reset     (reset),
        .req_i     (req_a),
        .data_i    (data_a),
        .ack_o     (ack_a),
        .q_o       (q_a),
        .q_valid_o (qv_a),
        .last_id_o (last_a),
        .busy_o    (busy_a)
    );

    rr_reg_arbiter #(.NUM_REQ(3), .DATA_W(8), .COOLDOWN(3)) dut_b (
        .clk       (clk),
        .reset     (reset),
        .req_i     (req_b),
        .data_i    (data_b),
        .ack_o     (ack_b),
        .q_o       (q_b),
        .q_valid_o (qv_b),
        .last_id_o (last_b),
        .busy_o    (busy_b)
    );

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: cool counts remaining busy cycles, zero means idle
    typedef struct {
        int ptr;
        int cool;
        int q;
        int valid;
        int last;
        int ack;
    } mstate_t;

    mstate_t m [2];

    function automatic mstate_t model_next(input mstate_t s, input int n, input int cd,
                                           input int req, input logic [31:0] data);
        mstate_t r;
        int eff;
        int w;
        r = s;
        r.ack = 0;
        if (s.cool > 0) begin
            r.cool = s.cool - 1;
        end else begin
            eff = req & ~s.ack;
            w = -1;
            for (int k = 0; k < n; k++) begin
                int c;
                c = (s.ptr + k) % n;
                if (w < 0 && ((eff >> c) & 1) == 1) w = c;
            end
            if (w >= 0) begin
                r.q     = int'(data[w*8 +: 8]);
                r.ack   = 1 << w;
                r.last  = w;
                r.valid = 1;
                r.ptr   = (w + 1) % n;
                r.cool  = cd;
            end
        end
        return r;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m[0] <= '{default: 0};
            m[1] <= '{default: 0};
        end else begin
            m[0] <= model_next(m[0], 4, 0, int'(req_a), data_a);
            m[1] <= model_next(m[1], 3, 3, int'(req_b), {8'h00, data_b});
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("a_ack",   32'(ack_a),  m[0].ack);
            check("a_q",     32'(q_a),    m[0].q);
            check("a_valid", 32'(qv_a),   m[0].valid);
            check("a_last",  32'(last_a), m[0].last);
            check("a_busy",  32'(busy_a), 32'(m[0].cool != 0));
            check("b_ack",   32'(ack_b),  m[1].ack);
            check("b_q",     32'(q_b),    m[1].q);
            check("b_valid", 32'(qv_b),   m[1].valid);
            check("b_last",  32'(last_b), m[1].last);
            check("b_busy",  32'(busy_b), 32'(m[1].cool != 0));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        int k;
        req_a  = 4'($urandom);
        data_a = $urandom;
        req_b  = 3'($urandom);
        data_b = 24'($urandom);
        tick();
        chk_en = 1'b1;
        tick();
        tick();
        check("rst_a_ack",   32'(ack_a),  0);
        check("rst_a_q",     32'(q_a),    0);
        check("rst_a_valid", 32'(qv_a),   0);
        check("rst_a_last",  32'(last_a), 0);
        check("rst_b_busy",  32'(busy_b), 0);
        check("rst_b_q",     32'(q_b),    0);

        // Release with a single request from requester 2
        req_a = 4'b0100;
        data_a[23:16] = 8'hA5;
        req_b = '0;
        reset = 1'b0;
        tick();
        check("rel_q",     32'(q_a),    32'hA5);
        check("rel_ack",   32'(ack_a),  32'b0100);
        check("rel_last",  32'(last_a), 2);
        check("rel_valid", 32'(qv_a),   1);
        req_a = '0;
        tick();

        // Round-robin with all requests held
        reset = 1'b1;
        tick();
        reset = 1'b0;
        data_a = 32'h44332211;
        req_a  = 4'hF;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rr_ack", 32'(ack_a), 32'(1 << (i % 4)));
            check("rr_q",   32'(q_a),   32'((i % 4 + 1) * 8'h11));
        end
        req_a = '0;
        tick();

        // Ack masking: a late-dropped request is not served in its ack cycle
        req_a = 4'b0010;
        tick();
        check("mask_first",  32'(ack_a), 32'b0010);
        tick();
        check("mask_hold",   32'(ack_a), 0);
        tick();
        check("mask_second", 32'(ack_a), 32'b0010);
        req_a = '0;
        tick();
        check("mask_drop",   32'(ack_a), 0);

        // Cooldown of 3 with requesters 0 and 1 continuously asking
        reset = 1'b1;
        tick();
        reset = 1'b0;
        data_b = 24'hC2B1A0;
        req_b  = 3'b011;
        for (int t = 1; t <= 12; t++) begin
            tick();
            check("cool_ack",  32'(ack_b),  (t % 4 == 1) ? (((t / 4) % 2 == 0) ? 1 : 2) : 0);
            check("cool_busy", 32'(busy_b), 32'(t % 4 != 0));
        end

        // Wrap with three requesters: after a grant to 2, requester 0 wins over 2
        req_b = 3'b100;
        tick();
        check("wrap_g2",   32'(ack_b),  32'b100);
        check("wrap_l2",   32'(last_b), 2);
        req_b = 3'b101;
        k = 0;
        do begin
            tick();
            k++;
        end while (ack_b == '0 && k < 8);
        check("wrap_g0",   32'(ack_b), 32'b001);
        check("wrap_q0",   32'(q_b),   32'hA0);
        check("wrap_gap",  k, 4);

        // Reset asserted during cooldown clears outputs without waiting for clk
        tick();
        check("midcool_busy", 32'(busy_b), 1);
        reset = 1'b1;
        #1;
        check("mid_b_busy",  32'(busy_b), 0);
        check("mid_b_q",     32'(q_b),    0);
        check("mid_b_valid", 32'(qv_b),   0);
        check("mid_b_last",  32'(last_b), 0);
        check("mid_b_ack",   32'(ack_b),  0);
        check("mid_a_valid", 32'(qv_a),   0);
        req_b = 3'b101;
        tick();
        reset = 1'b0;
        tick();
        check("post_ack",   32'(ack_b),  32'b001);
        check("post_last",  32'(last_b), 0);
        check("post_valid", 32'(qv_b),   1);
        check("post_q",     32'(q_b),    32'hA0);
        req_b = '0;
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/rr_reg_arbiter.md
# rr_reg_arbiter

Round-robin arbiter that shares one resettable storage register among `NUM_REQ` requesters. Each cycle it picks at most one pending request, loads that requester's data into the shared flop, and acknowledges the winner. After each write, an optional cooldown models settle time on the shared resource. The block sits between several producers and the single asynchronously reset D-flop bank they all update.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters; must be ≥ 2.
- `DATA_W`, default 8: width of the shared register.
- `COOLDOWN`, default 0: idle cycles forced after every write; 0 allows back-to-back writes.

Ports:
- `clk`  in  1  clock; all state updates on posedge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_i`  in  NUM_REQ  per-requester request; held until acknowledged.
- `data_i`  in  NUM_REQ*DATA_W  flattened write data; requester k occupies bits [k*DATA_W +: DATA_W]; held with its request.
- `ack_o`  out  NUM_REQ  one-hot, one-cycle pulse; bit k high in the cycle after requester k's data was captured.
- `q_o`  out  DATA_W  shared register contents.
- `q_valid_o`  out  1  sticky; goes high on the first write after reset.
- `last_id_o`  out  $clog2(NUM_REQ)  index of the most recent writer.
- `busy_o`  out  1  high while in cooldown.

## Operation
- **Reset values:** state IDLE, priority pointer 0, `q_o`=0, `q_valid_o`=0, `ack_o`=0, `last_id_o`=0, `busy_o`=0, cooldown counter 0.
- **FSM states:** IDLE and COOL.
- **IDLE:**
  - The effective request is `req_i & ~ack_o`. The acknowledged requester is masked in its ack cycle, so a requester that drops `req_i` one cycle late is not served twice.
  - If any effective request is present, the winner is the first set bit at or above the pointer, scanning upward and wrapping from NUM_REQ-1 to 0.
  - On the next edge: `q_o` ← winner's `data_i`, `ack_o` ← onehot(winner), `last_id_o` ← winner, `q_valid_o` ← 1, pointer ← (winner+1) mod NUM_REQ.
  - If COOLDOWN>0, go to COOL with counter = COOLDOWN; otherwise stay in IDLE.
  - With no effective request: no change, and `ack_o`=0.
- **COOL:**
  - `busy_o`=1. Requests are ignored, not queued. `q_o` holds.
  - The counter decrements each cycle; when it reaches 1, go to IDLE on the next edge.
  - Result: exactly COOLDOWN cycles with `busy_o`=1 between the ack cycle and the next sampling cycle.
- **Pointer wrap:** pointer arithmetic is modulo NUM_REQ. NUM_REQ need not be a power of two; pointer values ≥ NUM_REQ never occur.
- **Fairness:** with all requests held continuously, grants cycle 0,1,…,NUM_REQ-1,0,…
- **Reset mid-operation:** asserting `reset` at any point, including during COOL or an ack cycle, returns all outputs to reset values immediately (asynchronously). A pending ack is lost, and the requester must keep `req_i` high.

## Timing
- Latency from request sampled at edge T (state IDLE) to `q_o` updated and `ack_o` pulsing: T+1.
- Throughput: one write per (1+COOLDOWN) cycles.
- `ack_o` is high for exactly one cycle per write. At most one bit of `ack_o` is ever high.
- Requester rule: `data_i` must be stable while `req_i` is high and no ack has been seen. Deasserting `req_i` before ack withdraws the request without penalty.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package `rr_arb_pkg`:
  - state enum typedef `arb_state_t` {ARB_IDLE, ARB_COOL};
  - helper functions for index width `$clog2` and wrap increment.
- Sub-module `rr_priority_pick`: purely combinational.
  - Inputs: request vector and pointer.
  - Outputs: found flag and winner index.
  - Implemented with a double-width masked priority scan.
- Top module holds the FSM, cooldown counter, pointer, and the output registers.

## Test plan
- **Reset:** hold `reset` high with random `req_i`/`data_i` → all outputs 0. Release with `req_i`=4'b0100 and data[2]=8'hA5 → next cycle `q_o`=8'hA5, `ack_o`=4'b0100, `last_id_o`=2, `q_valid_o`=1.
- **Round-robin (NUM_REQ=4, COOLDOWN=0):** all `req_i` held high → `ack_o` sequence 0001, 0010, 0100, 1000, 0001 on consecutive cycles, and `q_o` tracks each requester's data.
- **Ack masking:** a requester keeps `req_i` high for one cycle after its ack while others are idle → no second ack in that cycle; a second ack occurs only if `req_i` is still high the cycle after.
- **Cooldown (COOLDOWN=3):** continuous requests from 0 and 1 → ack pulses 4 cycles apart, alternating 0,1, with `busy_o`=1 for exactly 3 cycles between acks.
- **Wrap with NUM_REQ=3:** after a grant to requester 2, requests from 0 and 2 pending → requester 0 wins first.
- **Reset mid-cooldown:** assert `reset` during COOL → outputs return to 0 immediately. After release, a pending request is granted one cycle later and the pointer starts at 0.
